// File: rtl/filter_stage.sv
// 4-tap moving-average filter stage with valid/ready streaming on both sides.
// Optional build macro FILTER_ROUND_EN selects round-half-up instead of truncation.
module filter_stage #(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              filter_enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              filter_done,
    output logic              busy,
    output logic [7:0]        sample_count
);

    localparam int unsigned SUM_W = DATA_W + 2;
    localparam logic [7:0]  LAST_IDX = 8'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] h1_q, h1_d;
    logic [DATA_W-1:0] h2_q, h2_d;
    logic [DATA_W-1:0] h3_q, h3_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        count_q, count_d;

    logic              accept;
    logic              xfer;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_adj;
    logic [DATA_W-1:0] result;

    // Input may be taken only while the output register is free or draining now.
    assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    assign sum = SUM_W'(in_data) + SUM_W'(h1_q) + SUM_W'(h2_q) + SUM_W'(h3_q);
`ifdef FILTER_ROUND_EN
    assign sum_adj = sum + SUM_W'(2);
`else
    assign sum_adj = sum;
`endif
    assign result = DATA_W'(sum_adj >> 2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            h1_q        <= '0;
            h2_q        <= '0;
            h3_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            h1_q        <= h1_d;
            h2_q        <= h2_d;
            h3_q        <= h3_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        h1_d        = h1_q;
        h2_d        = h2_q;
        h3_d        = h3_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        count_d     = count_q;

        case (state_q)
            S_IDLE: begin
                if (filter_enable) begin
                    state_d = S_RUN;
                    h1_d    = '0;
                    h2_d    = '0;
                    h3_d    = '0;
                    count_d = '0;
                end
            end
            S_RUN: begin
                if (accept && (count_q == LAST_IDX)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new accept in the same cycle as a transfer keeps the output full.
        if (xfer) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = result;
            h3_d        = h2_q;
            h2_d        = h1_q;
            h1_d        = in_data;
            count_d     = count_q + 8'd1;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign filter_done  = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign sample_count = count_q;

endmodule
